// File: rtl/bcd_frequency_meter.sv
// bcd_frequency_meter: counts signal_in rising edges over a calibrated gate window, reports 4 BCD digits
// Ports: clk_clk / reset_reset_n   clock, asynchronous active-low reset
//        signal_in                 asynchronous pulse input to be counted
//        calibration               gate select: 1 BASE/10, 2 BASE/100, 3 BASE/1000, others BASE
//        milliers..unites          BCD digits of the last completed window
//        overflow                  last completed window counted more than 9999 edges
//        update                    one-cycle strobe when the outputs reload
module bcd_frequency_meter #(
  parameter int GATE_BASE_CYCLES = 50000000,
  parameter int SYNC_STAGES      = 2
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       signal_in,
  input  logic [2:0] calibration,
  output logic [3:0] unites,
  output logic [3:0] dizaines,
  output logic [3:0] centaines,
  output logic [3:0] milliers,
  output logic       overflow,
  output logic       update
);
  localparam int TW = $clog2(GATE_BASE_CYCLES);
  // Reload values are G-2: INIT/LATCH/abort take one cycle and the timer==0 cycle is the last COUNT cycle
  localparam logic [TW-1:0] G0 = TW'(GATE_BASE_CYCLES - 2);
  localparam logic [TW-1:0] G1 = TW'(GATE_BASE_CYCLES / 10 - 2);
  localparam logic [TW-1:0] G2 = TW'(GATE_BASE_CYCLES / 100 - 2);
  localparam logic [TW-1:0] G3 = TW'(GATE_BASE_CYCLES / 1000 - 2);
  typedef enum logic [1:0] {INIT, COUNT, LATCH} state_t;
  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   edge_w;
  logic                   sat_w;
  logic [2:0]             cal_q;
  logic [TW-1:0]          timer_q;
  logic [TW-1:0]          reload_w;
  logic [15:0]            cnt_q;
  logic [15:0]            cnt_d;
  logic                   ovf_q;
  logic                   ovf_d;
  logic [15:0]            digits_q;
  logic                   overflow_q;
  logic                   update_q;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        r[4*i +: 4] = v[4*i +: 4] == 4'd9 ? 4'd0 : v[4*i +: 4] + 4'd1;
        c = v[4*i +: 4] == 4'd9;
      end
    end
    return r;
  endfunction

  assign edge_w   = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign sat_w    = cnt_q == 16'h9999;
  assign cnt_d    = edge_w && !sat_w ? bcd_inc(cnt_q) : cnt_q;
  assign ovf_d    = ovf_q | (edge_w & sat_w);
  assign reload_w = calibration == 3'd1 ? G1 :
                    calibration == 3'd2 ? G2 :
                    calibration == 3'd3 ? G3 : G0;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= INIT;
      sync_q     <= '0;
      dly_q      <= 1'b0;
      cal_q      <= '0;
      timer_q    <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
      update_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], signal_in};
      dly_q    <= sync_q[SYNC_STAGES-1];
      update_q <= 1'b0;
      case (state_q)
        INIT: begin
          cal_q   <= calibration;
          timer_q <= reload_w;
          state_q <= COUNT;
        end
        COUNT: begin
          // A calibration change restarts the window with the new gate; the partial count is dropped
          if (calibration != cal_q) begin
            cal_q   <= calibration;
            timer_q <= reload_w;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end else begin
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            timer_q <= timer_q - TW'(1);
            if (timer_q == '0) state_q <= LATCH;
          end
        end
        LATCH: begin
          // The edge of this cycle still belongs to the closing window
          digits_q   <= cnt_d;
          overflow_q <= ovf_d;
          update_q   <= 1'b1;
          cnt_q      <= '0;
          ovf_q      <= 1'b0;
          cal_q      <= calibration;
          timer_q    <= reload_w;
          state_q    <= COUNT;
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign {milliers, centaines, dizaines, unites} = digits_q;
  assign overflow = overflow_q;
  assign update   = update_q;
endmodule

// File: tb/tb_bcd_frequency_meter.sv
// tb_bcd_frequency_meter: table vectors, hand sequences and random traffic against a window-count model
module tb_bcd_frequency_meter;
  localparam int BASE = 40000;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       signal_in = 1'b0;
  logic [2:0] calibration = 3'd0;
  logic [3:0] unites, dizaines, centaines, milliers;
  logic       overflow, update;
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic       prev_in = 1'b0;
  bit         ehit [131072];
  logic [2:0] calh [131072];
  int         upd_cyc[$];
  logic [15:0] upd_val[$];
  logic       upd_ovf[$];
  logic [15:0] hold_val = 16'h0;
  logic       hold_ovf = 1'b0;
  int         m_g, m_n, m_lo;

  typedef struct {
    logic [2:0]  cal;
    int          per;
    int          nrise;
    logic [15:0] exp1;
    logic        ovf1;
    bit          two;
    logic [15:0] exp2;
  } vec_t;
  vec_t vecs[8];

  bcd_frequency_meter #(.GATE_BASE_CYCLES(BASE), .SYNC_STAGES(2)) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .signal_in(signal_in),
    .calibration(calibration),
    .unites(unites),
    .dizaines(dizaines),
    .centaines(centaines),
    .milliers(milliers),
    .overflow(overflow),
    .update(update)
  );

  always #5 clk = ~clk;

  function automatic int gate(input logic [2:0] c);
    return c == 3'd1 ? BASE / 10 : c == 3'd2 ? BASE / 100 : c == 3'd3 ? BASE / 1000 : BASE;
  endfunction

  function automatic int to_bcd(input int n);
    int s;
    s = n > 9999 ? 9999 : n;
    return ((s / 1000) << 12) | (((s / 100) % 10) << 8) | (((s / 10) % 10) << 4) | (s % 10);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A rise seen at clock p is counted by the meter at clock p+2 (two sync stages)
  always @(posedge clk) begin
    cyc <= cyc + 1;
    calh[cyc+1] <= calibration;
    if (signal_in && !prev_in) ehit[cyc+3] <= 1'b1;
    prev_in <= signal_in;
  end

  // Model: an update visible after clock L reports the edges counted in clocks L-G+1..L
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      chk("reset_outputs", {update, overflow, milliers, centaines, dizaines, unites}, 0);
      hold_val = 16'h0;
      hold_ovf = 1'b0;
    end else if (update) begin
      m_g  = gate(calh[cyc]);
      m_lo = cyc - m_g + 1;
      if (m_lo < 0) m_lo = 0;
      m_n = 0;
      for (int i = m_lo; i <= cyc; i++) m_n += int'(ehit[i]);
      hold_val = 16'(to_bcd(m_n));
      hold_ovf = m_n > 9999;
      chk("window_value", {overflow, milliers, centaines, dizaines, unites}, {hold_ovf, hold_val});
      upd_cyc.push_back(cyc);
      upd_val.push_back({milliers, centaines, dizaines, unites});
      upd_ovf.push_back(overflow);
    end else begin
      chk("hold_between_updates", {overflow, milliers, centaines, dizaines, unites}, {hold_ovf, hold_val});
    end
  end

  task automatic run(input int ncyc, input int per, input int nrise, input bit rnd);
    int r;
    r = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (rnd) signal_in = 1'($urandom_range(0, 1));
      else if (r < nrise && c % per == 0) begin
        signal_in = 1'b1;
        r++;
      end else signal_in = 1'b0;
      @(negedge clk);
    end
    signal_in = 1'b0;
  endtask

  task automatic do_reset(input logic [2:0] c, output int rel);
    @(negedge clk);
    rst_n = 1'b0;
    calibration = c;
    for (int i = 0; i < 5; i++) begin
      signal_in = i < 2 ? ~signal_in : 1'b0;
      @(negedge clk);
    end
    rst_n = 1'b1;
    rel = cyc;
    upd_cyc.delete();
    upd_val.delete();
    upd_ovf.delete();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, a0, k;
    vecs[0] = '{3'd2, 8, 50, 16'h0050, 1'b0, 1'b1, 16'h0000};
    vecs[1] = '{3'd1, 3, 1099, 16'h1099, 1'b0, 1'b0, 16'h0000};
    vecs[2] = '{3'd1, 3, 1000, 16'h1000, 1'b0, 1'b0, 16'h0000};
    vecs[3] = '{3'd3, 2, 3, 16'h0003, 1'b0, 1'b1, 16'h0000};
    vecs[4] = '{3'd3, 2, 20, 16'h0020, 1'b0, 1'b1, 16'h0000};
    vecs[5] = '{3'd3, 2, 21, 16'h0020, 1'b0, 1'b1, 16'h0001};
    vecs[6] = '{3'd3, 2, 25, 16'h0020, 1'b0, 1'b1, 16'h0005};
    vecs[7] = '{3'd0, 2, 10050, 16'h9999, 1'b1, 1'b0, 16'h0000};
    for (int v = 0; v < 8; v++) begin
      int g;
      g = gate(vecs[v].cal);
      do_reset(vecs[v].cal, r);
      run(vecs[v].two ? 2 * g + 5 : g + 5, vecs[v].per, vecs[v].nrise, 1'b0);
      chk($sformatf("vec%0d_update_count", v), upd_cyc.size(), vecs[v].two ? 2 : 1);
      if (upd_cyc.size() > 0) begin
        chk($sformatf("vec%0d_first_update_delay", v), upd_cyc[0] - r, g + 1);
        chk($sformatf("vec%0d_window1", v), {upd_ovf[0], upd_val[0]}, {vecs[v].ovf1, vecs[v].exp1});
      end
      if (vecs[v].two && upd_cyc.size() > 1) begin
        chk($sformatf("vec%0d_period", v), upd_cyc[1] - upd_cyc[0], g);
        chk($sformatf("vec%0d_window2", v), {upd_ovf[1], upd_val[1]}, {1'b0, vecs[v].exp2});
      end
    end
    upd_cyc.delete();
    upd_val.delete();
    upd_ovf.delete();
    calibration = 3'd3;
    a0 = cyc;
    run(45, 2, 3, 1'b0);
    chk("after_ovf_update_count", upd_cyc.size(), 1);
    if (upd_cyc.size() > 0) begin
      chk("after_ovf_update_delay", upd_cyc[0] - a0, 41);
      chk("after_ovf_value", {upd_ovf[0], upd_val[0]}, {1'b0, 16'h0003});
    end
    do_reset(3'd2, r);
    run(1210, 8, 1000, 1'b0);
    chk("periodic_update_count", upd_cyc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < upd_cyc.size()) begin
        chk($sformatf("periodic_cycle%0d", i), upd_cyc[i] - r, 401 + 400 * i);
        chk($sformatf("periodic_value%0d", i), {upd_ovf[i], upd_val[i]}, {1'b0, 16'h0050});
      end
    end
    do_reset(3'd2, r);
    run(200, 8, 1000, 1'b0);
    calibration = 3'd3;
    a0 = cyc;
    run(50, 8, 1000, 1'b0);
    chk("abort_update_count", upd_cyc.size(), 1);
    if (upd_cyc.size() > 0) begin
      chk("abort_update_delay", upd_cyc[0] - a0, 41);
      chk("abort_value", {upd_ovf[0], upd_val[0]}, {1'b0, 16'h0005});
    end
    rst_n = 1'b0;
    #1;
    chk("async_reset_clears", {update, overflow, milliers, centaines, dizaines, unites}, 0);
    do_reset(3'd2, r);
    for (int s = 0; s < 12; s++) begin
      k = $urandom_range(0, 3);
      calibration = k == 0 ? 3'd2 : k == 1 ? 3'd3 : k == 2 ? 3'd4 : 3'd7;
      run($urandom_range(100, 600), 0, 0, 1'b1);
    end
    calibration = 3'd3;
    run(200, 0, 0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
